// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
//   cla_op_t     : operation select (ADD, SUB, ADC, SBB)
//   op_inverts_b : 1 when the B operand is complemented (subtract forms)
//   op_carry_in  : effective carry into bit 0 for a given op and cin
package cla_pkg;

  typedef enum logic [1:0] {CLA_ADD, CLA_SUB, CLA_ADC, CLA_SBB} cla_op_t;

  function automatic logic op_inverts_b(cla_op_t op);
    return (op == CLA_SUB) || (op == CLA_SBB);
  endfunction

  // SBB takes cin as a borrow, so the carry into the adder is its inverse.
  function automatic logic op_carry_in(cla_op_t op, logic cin);
    logic c;
    case (op)
      CLA_ADD: c = 1'b0;
      CLA_SUB: c = 1'b1;
      CLA_ADC: c = cin;
      default: c = ~cin;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group, purely combinational.
//   a, b_eff : group slice of operand A and effective operand B
//   c_in     : carry into the group's LSB
//   g_grp    : group generate (fully expanded lookahead form)
//   p_grp    : group propagate
//   s        : group sum bits given c_in
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b_eff,
  input  logic             c_in,
  output logic             g_grp,
  output logic             p_grp,
  output logic [GROUP-1:0] s
);

  logic [GROUP-1:0] g, p, c;
  logic             term;

  // p is the OR form; it is only used for lookahead, never for the sum.
  assign g = a & b_eff;
  assign p = a | b_eff;

  always_comb begin
    g_grp = 1'b0;
    p_grp = &p;
    c     = '0;
    term  = 1'b0;
    // G = g[n-1] | p[n-1]g[n-2] | ... | p[n-1..1]g[0]
    for (int i = 0; i < GROUP; i++) begin
      term = g[i];
      for (int j = i + 1; j < GROUP; j++) term = term & p[j];
      g_grp = g_grp | term;
    end
    // Internal carries, each expanded from c_in and the bit g/p terms.
    for (int i = 0; i < GROUP; i++) begin
      c[i] = c_in;
      for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int k = 0; k < i; k++) begin
        term = g[k];
        for (int j = k + 1; j < i; j++) term = term & p[j];
        c[i] = c[i] | term;
      end
    end
  end

  assign s = a ^ b_eff ^ c;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, cin, op)
//   out_valid/out_ready : result handshake (sum, cout, ovf, zero)
// S1 registers effective operands plus per-group G/P; S2 resolves group
// carries, forms sums and registers the result and flags.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  cla_op_t          op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG  = WIDTH / GROUP;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_param
    $error("WIDTH must be a non-zero multiple of GROUP");
  end

  // ---------------- handshake ----------------
  logic v1_q, v1_d, v2_q, v2_d;
  logic s1_load, s2_load;

  assign s2_load   = v1_q & (~v2_q | out_ready);
  assign in_ready  = ~rst & (~v1_q | s2_load);
  assign s1_load   = in_valid & in_ready;
  assign out_valid = v2_q;

  always_comb begin
    v1_d = s1_load | (v1_q & ~s2_load);
    v2_d = s2_load | (v2_q & ~out_ready);
  end

  // ---------------- stage 1 ----------------
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [NG-1:0]    g_in, p_in;
  logic [WIDTH-1:0] s1_sum_unused;

  assign b_eff = op_inverts_b(op) ? ~b : b;
  assign c_eff = op_carry_in(op, cin);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             c_q, c_d;
  logic [NG-1:0]    g_q, g_d, p_q, p_d;

  for (genvar k = 0; k < NG; k++) begin : g_s1
    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (a[k*GROUP +: GROUP]),
      .b_eff (b_eff[k*GROUP +: GROUP]),
      .c_in  (1'b0),
      .g_grp (g_in[k]),
      .p_grp (p_in[k]),
      .s     (s1_sum_unused[k*GROUP +: GROUP])
    );
  end

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    g_d = g_q;
    p_d = p_q;
    if (s1_load) begin
      a_d = a;
      b_d = b_eff;
      c_d = c_eff;
      g_d = g_in;
      p_d = p_in;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    c_q <= c_d;
    g_q <= g_d;
    p_q <= p_d;
  end

  // ---------------- stage 2 ----------------
  // Group carries, each expanded directly from registered G/P and c_q so
  // no carry depends on another carry.
  logic [NG:0] gc;

  for (genvar k = 0; k <= NG; k++) begin : g_lookahead
    logic ck, t;
    always_comb begin
      ck = c_q;
      t  = 1'b0;
      for (int j = 0; j < k; j++) ck = ck & p_q[j];
      for (int m = 0; m < k; m++) begin
        t = g_q[m];
        for (int j = m + 1; j < k; j++) t = t & p_q[j];
        ck = ck | t;
      end
    end
    assign gc[k] = ck;
  end

  logic [WIDTH-1:0] sum_nxt;
  logic [NG-1:0]    s2_g_unused, s2_p_unused;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    cla_group #(.GROUP(GROUP)) u_grp (
      .a     (a_q[k*GROUP +: GROUP]),
      .b_eff (b_q[k*GROUP +: GROUP]),
      .c_in  (gc[k]),
      .g_grp (s2_g_unused[k]),
      .p_grp (s2_p_unused[k]),
      .s     (sum_nxt[k*GROUP +: GROUP])
    );
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (s2_load) begin
      sum_d  = sum_nxt;
      cout_d = gc[NG];
      ovf_d  = (a_q[MSB] == b_q[MSB]) & (sum_nxt[MSB] != a_q[MSB]);
      zero_d = ~|sum_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;
  import cla_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        cin = 1'b0;
  cla_op_t     op = CLA_ADD;

  logic        rdy16, ov16, co16, of16, z16;
  logic [15:0] s16;
  logic        rdy32, ov32, co32, of32, z32;
  logic [31:0] s32;
  logic        rdy8, ov8, co8, of8, z8;
  logic [7:0]  s8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .a(a32[15:0]), .b(b32[15:0]), .cin(cin), .op(op),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16), .zero(z16));

  pipelined_cla_addsub #(.WIDTH(32), .GROUP(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .a(a32), .b(b32), .cin(cin), .op(op),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32), .zero(z32));

  pipelined_cla_addsub #(.WIDTH(8), .GROUP(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .a(a32[7:0]), .b(b32[7:0]), .cin(cin), .op(op),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8), .zero(z8));

  // Behavioural reference: {zero, ovf, cout, sum} for a w-bit operation.
  function automatic logic [34:0] model(int w, cla_op_t o, logic [31:0] x, logic [31:0] y, logic ci);
    logic [63:0] mask, xa, ya, t;
    logic [31:0] s;
    logic        ce;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'b0, x} & mask;
    ya   = ((o == CLA_SUB || o == CLA_SBB) ? ~{32'b0, y} : {32'b0, y}) & mask;
    case (o)
      CLA_ADD: ce = 1'b0;
      CLA_SUB: ce = 1'b1;
      CLA_ADC: ce = ci;
      default: ce = ~ci;
    endcase
    t = xa + ya + {63'b0, ce};
    s = t[31:0] & mask[31:0];
    return {s == 32'b0, (xa[w-1] == ya[w-1]) && (s[w-1] != xa[w-1]), t[w], s};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", rdy16); end
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", ov16); end
    n_checks++; if ({s16, co16, of16, z16} !== 19'h0) begin n_fail++; $display("FAIL rst_outputs got=%h/%b%b%b exp=0", s16, co16, of16, z16); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got=%b exp=1", rdy16); end
    next_cycle();
  endtask

  typedef struct {
    cla_op_t     o;
    logic [15:0] x, y;
    logic        ci;
    logic [15:0] s;
    logic        co, of, z;
  } vec_t;

  task automatic test_arith();
    vec_t v[6];
    v[0] = '{CLA_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[1] = '{CLA_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    v[2] = '{CLA_SUB, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    v[3] = '{CLA_ADC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    v[4] = '{CLA_SBB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    v[5] = '{CLA_SBB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; op = v[i].o; a32 = {16'h0, v[i].x}; b32 = {16'h0, v[i].y}; cin = v[i].ci;
      @(negedge clk);
      n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL arith%0d_in_ready got=%b exp=1", i, rdy16); end
      next_cycle();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL arith%0d_early_valid got=%b exp=0", i, ov16); end
      next_cycle();
      @(negedge clk);
      n_checks++; if (ov16 !== 1'b1) begin n_fail++; $display("FAIL arith%0d_valid got=%b exp=1", i, ov16); end
      n_checks++; if (s16 !== v[i].s) begin n_fail++; $display("FAIL arith%0d_sum got=%h exp=%h", i, s16, v[i].s); end
      n_checks++; if (co16 !== v[i].co) begin n_fail++; $display("FAIL arith%0d_cout got=%b exp=%b", i, co16, v[i].co); end
      n_checks++; if (of16 !== v[i].of) begin n_fail++; $display("FAIL arith%0d_ovf got=%b exp=%b", i, of16, v[i].of); end
      n_checks++; if (z16 !== v[i].z) begin n_fail++; $display("FAIL arith%0d_zero got=%b exp=%b", i, z16, v[i].z); end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; op = CLA_ADD; cin = 1'b0;
    in_valid = 1'b1; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_beat1 got=%b exp=1", rdy16); end
    next_cycle();
    a32 = 32'd2; b32 = 32'd2;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_beat2 got=%b exp=1", rdy16); end
    next_cycle();
    a32 = 32'd3; b32 = 32'd3;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full got=%b exp=0", rdy16); end
    n_checks++; if ({ov16, s16} !== {1'b1, 16'h0002}) begin n_fail++; $display("FAIL bp_head got=%b/%h exp=1/0002", ov16, s16); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({rdy16, ov16, s16} !== {2'b01, 16'h0002}) begin n_fail++; $display("FAIL bp_hold got=%b%b/%h exp=01/0002", rdy16, ov16, s16); end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_release got=%b exp=1", rdy16); end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({ov16, s16} !== {1'b1, 16'h0004}) begin n_fail++; $display("FAIL bp_second got=%b/%h exp=1/0004", ov16, s16); end
    next_cycle();
    @(negedge clk);
    n_checks++; if ({ov16, s16} !== {1'b1, 16'h0006}) begin n_fail++; $display("FAIL bp_third got=%b/%h exp=1/0006", ov16, s16); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", ov16); end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; op = CLA_ADD; cin = 1'b0;
    in_valid = 1'b1; a32 = 32'd1; b32 = 32'd1;
    next_cycle();
    a32 = 32'd2; b32 = 32'd2;
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy16 !== 1'b0) begin n_fail++; $display("FAIL mrst_rdy_in_rst got=%b exp=0", rdy16); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ov16, s16, co16, of16, z16} !== 20'h0) begin n_fail++; $display("FAIL mrst_cleared got=%b/%h exp=0/0000", ov16, s16); end
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL mrst_rdy_after got=%b exp=1", rdy16); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL mrst_stale%0d got=%b exp=0", i, ov16); end
    end
    next_cycle();
  endtask

  // Random sweep on the 32/8 and 8/8 instances with a scoreboard per width.
  task automatic test_sweep();
    logic [34:0] q32[$], q8[$];
    logic [34:0] got, exp;
    logic        hold = 1'b0;
    int          nb = 0;
    logic [31:0] ta[5] = '{32'h00FFFFFF, 32'hFFFFFFFF, 32'h0000FFFF, 32'h000000FF, 32'h7FFFFFFF};
    logic [31:0] tb[5] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    for (int cyc = 0; cyc < 430; cyc++) begin
      if (cyc >= 400) begin
        in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (!hold) begin
          in_valid = ($urandom_range(0, 3) != 0);
          if (nb < 5) begin
            op = CLA_ADD; a32 = ta[nb]; b32 = tb[nb]; cin = 1'b0;
          end else begin
            op = cla_op_t'($urandom_range(0, 3)); a32 = $urandom; b32 = $urandom; cin = $urandom_range(0, 1) != 0;
          end
        end
      end
      @(negedge clk);
      if (ov32 && out_ready) begin
        got = {z32, of32, co32, s32};
        n_checks++;
        if (q32.size() == 0) begin n_fail++; $display("FAIL sweep32_extra got=%h exp=none", got); end
        else begin exp = q32.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL sweep32 got=%h exp=%h", got, exp); end end
      end
      if (ov8 && out_ready) begin
        got = {z8, of8, co8, 24'h0, s8};
        n_checks++;
        if (q8.size() == 0) begin n_fail++; $display("FAIL sweep8_extra got=%h exp=none", got); end
        else begin exp = q8.pop_front(); if (got !== exp) begin n_fail++; $display("FAIL sweep8 got=%h exp=%h", got, exp); end end
      end
      if (in_valid && rdy32) q32.push_back(model(32, op, a32, b32, cin));
      if (in_valid && rdy8)  q8.push_back(model(8, op, a32, b32, cin));
      if (in_valid && rdy32) nb++;
      hold = in_valid && !rdy32;
      next_cycle();
    end
    n_checks++; if (q32.size() != 0) begin n_fail++; $display("FAIL sweep32_lost got=%0d exp=0", q32.size()); end
    n_checks++; if (q8.size() != 0) begin n_fail++; $display("FAIL sweep8_lost got=%0d exp=0", q8.size()); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
